// File: rtl/servant_uart_pkg.sv
// Shared types and constants for the servant UART blocks.
package servant_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAITHI
    } state_e;

    // 16 MHz / 57600 baud
    localparam int unsigned BAUD_DEFAULT = 278;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/servant_uart_baud.sv
// Loadable baud down-counter. Counts to zero and parks there; tick is
// high while the count is zero. Shared between receiver and transmitter.
module servant_uart_baud
    import servant_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = BAUD_DEFAULT,
    localparam int unsigned CW = cnt_w(CLKS_PER_BIT)
) (
    input  logic          wb_clk,
    input  logic          wb_rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          tick
);

    logic [CW-1:0] cnt_q, cnt_d;

    // Reload on request, otherwise count down and saturate at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    // Counter register.
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign tick = (cnt_q == '0);

endmodule

// File: rtl/servant_uart_rx.sv
// 8N1 serial receiver for the servant SoC console line.
// Define SERVANT_UART_RX_PARITY_EN to receive 8E1 frames instead; this adds
// a PARITY state and the rx_perr strobe.
module servant_uart_rx
    import servant_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT  = BAUD_DEFAULT,
    parameter int unsigned STOP_WAIT_MAX = 0
) (
    input  logic       wb_clk,
    input  logic       wb_rst,
    input  logic       q,
    output logic [7:0] rx_data,
    output logic       rx_vld,
    output logic       rx_ferr,
    output logic       rx_brk,
`ifdef SERVANT_UART_RX_PARITY_EN
    output logic       rx_perr,
`endif
    output logic       rx_busy
);

    localparam int unsigned CW = cnt_w(CLKS_PER_BIT);
    localparam int unsigned WW = cnt_w(STOP_WAIT_MAX + 1);
    localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT - 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(STOP_WAIT_MAX);

    state_e        state_q, state_d;
    logic [1:0]    sync_q, sync_d;
    logic          qs;
    logic          tick, load;
    logic [CW-1:0] load_val;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    data_q, data_d;
    logic          vld_q, vld_d;
    logic          ferr_q, ferr_d;
    logic          brk_q, brk_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          stop_ok;
`ifdef SERVANT_UART_RX_PARITY_EN
    logic          par_q, par_d;
    logic          perr_q, perr_d;
`endif

    // Two-flop synchroniser; resets to the idle-high line level.
    assign sync_d = {sync_q[0], q};
    assign qs     = sync_q[1];

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) sync_q <= 2'b11;
        else        sync_q <= sync_d;
    end

    // Counter restarts on every state change and on each data bit.
    assign load     = (state_d != state_q) || (state_q == DATA && tick);
    assign load_val = (state_d == START) ? HALF_BIT : FULL_BIT;

    servant_uart_baud #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .wb_clk  (wb_clk),
        .wb_rst  (wb_rst),
        .load    (load),
        .load_val(load_val),
        .tick    (tick)
    );

    // State register.
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; all sampling happens mid-bit on tick.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (!qs) state_d = START;
            START:  if (tick) state_d = qs ? IDLE : DATA;
`ifdef SERVANT_UART_RX_PARITY_EN
            DATA:   if (tick && idx_q == 3'd7) state_d = PARITY;
            PARITY: if (tick) state_d = STOP;
`else
            DATA:   if (tick && idx_q == 3'd7) state_d = STOP;
`endif
            STOP:   if (tick) state_d = qs ? IDLE : WAITHI;
            WAITHI: if (qs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Parity (when present) must leave an even count of ones.
`ifdef SERVANT_UART_RX_PARITY_EN
    assign stop_ok = ~^{shift_q, par_q};
`else
    assign stop_ok = 1'b1;
`endif

    // Datapath and strobe logic driven by the current state.
    always_comb begin
        shift_d = shift_q;
        idx_d   = idx_q;
        data_d  = data_q;
        vld_d   = 1'b0;
        ferr_d  = 1'b0;
        brk_d   = 1'b0;
        wait_d  = '0;
`ifdef SERVANT_UART_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = 1'b0;
`endif
        case (state_q)
            START: idx_d = 3'd0;
            DATA: begin
                if (tick) begin
                    shift_d = {qs, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                end
            end
`ifdef SERVANT_UART_RX_PARITY_EN
            PARITY: if (tick) par_d = qs;
`endif
            STOP: begin
                if (tick) begin
                    if (!qs) begin
                        ferr_d = 1'b1;
                    end else if (stop_ok) begin
                        vld_d  = 1'b1;
                        data_d = shift_q;
                    end else begin
`ifdef SERVANT_UART_RX_PARITY_EN
                        perr_d = 1'b1;
`endif
                    end
                end
            end
            WAITHI: begin
                // Break timer saturates at the limit so rx_brk holds.
                if (!qs && STOP_WAIT_MAX != 0) begin
                    wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + 1'b1;
                    brk_d  = (wait_d == WAIT_MAX);
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            shift_q <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            vld_q   <= 1'b0;
            ferr_q  <= 1'b0;
            brk_q   <= 1'b0;
            wait_q  <= '0;
`ifdef SERVANT_UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            shift_q <= shift_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            vld_q   <= vld_d;
            ferr_q  <= ferr_d;
            brk_q   <= brk_d;
            wait_q  <= wait_d;
`ifdef SERVANT_UART_RX_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    assign rx_data = data_q;
    assign rx_vld  = vld_q;
    assign rx_ferr = ferr_q;
    assign rx_brk  = brk_q;
    assign rx_busy = (state_q != IDLE);
`ifdef SERVANT_UART_RX_PARITY_EN
    assign rx_perr = perr_q;
`endif

endmodule

// File: tb/tb_servant_uart_rx.sv
// Randomised bench for servant_uart_rx: a frame-level model predicts each
// strobe (kind, cycle, data) from the bits put on the line.
`timescale 1ns/1ps
module tb_servant_uart_rx;

    localparam int C   = 16;
    localparam int SWM = 40;
`ifdef SERVANT_UART_RX_PARITY_EN
    localparam int NB  = 11;
`else
    localparam int NB  = 10;
`endif
    localparam int FL  = NB * C;                 // frame length on the line
    localparam int LAT = 2 + C/2 + (NB-1)*C + 1; // fall edge to strobe

    logic       wb_clk, wb_rst, q;
    logic [7:0] rx_data;
    logic       rx_vld, rx_ferr, rx_brk, rx_busy;
`ifdef SERVANT_UART_RX_PARITY_EN
    logic       rx_perr;
`endif

    servant_uart_rx #(.CLKS_PER_BIT(C), .STOP_WAIT_MAX(SWM)) dut (
        .wb_clk (wb_clk),
        .wb_rst (wb_rst),
        .q      (q),
        .rx_data(rx_data),
        .rx_vld (rx_vld),
        .rx_ferr(rx_ferr),
        .rx_brk (rx_brk),
`ifdef SERVANT_UART_RX_PARITY_EN
        .rx_perr(rx_perr),
`endif
        .rx_busy(rx_busy)
    );

    initial wb_clk = 1'b0;
    always #5 wb_clk = ~wb_clk;

    int cyc = 0;
    always @(posedge wb_clk) cyc <= cyc + 1;

    int n_chk = 0, n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // kind: 0 = byte received, 1 = framing error, 2 = parity error
    typedef struct {
        int         cyc;
        int         kind;
        logic [7:0] data;
    } ev_t;

    ev_t        obs_q[$];
    ev_t        exp_q[$];
    logic [7:0] last_data;

    // Record every strobe seen on the outputs, sampled mid-cycle.
    always @(negedge wb_clk) begin
        if (!wb_rst) begin
            if (rx_vld)  obs_q.push_back('{cyc, 0, rx_data});
            if (rx_ferr) obs_q.push_back('{cyc, 1, rx_data});
`ifdef SERVANT_UART_RX_PARITY_EN
            if (rx_perr) obs_q.push_back('{cyc, 2, rx_data});
`endif
            if (rx_vld || rx_ferr) check("vld_ferr_exclusive", {31'd0, rx_vld & rx_ferr}, 32'd0);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge wb_clk);
        #1;
    endtask

    function automatic logic even_par(input logic [7:0] d);
        return ($countones(d) % 2) != 0;
    endfunction

    // Predict the outcome of one frame, then drive it. Leaves q at the stop level.
    task automatic send(input logic [7:0] d, input logic stop, input logic par);
        ev_t e;
        e.cyc = cyc + LAT;
        if (!stop) begin
            e.kind = 1; e.data = last_data;
`ifdef SERVANT_UART_RX_PARITY_EN
        end else if (($countones({d, par}) % 2) != 0) begin
            e.kind = 2; e.data = last_data;
`endif
        end else begin
            e.kind = 0; e.data = d; last_data = d;
        end
        exp_q.push_back(e);
        q = 1'b0; tick(C);
        for (int i = 0; i < 8; i++) begin
            q = d[i]; tick(C);
        end
`ifdef SERVANT_UART_RX_PARITY_EN
        q = par; tick(C);
`endif
        q = stop; tick(C);
    endtask

    task automatic compare(input string tag);
        ev_t o, x;
        check($sformatf("%s_count", tag), obs_q.size(), exp_q.size());
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            x = exp_q.pop_front();
            check($sformatf("%s_cycle", tag), o.cyc, x.cyc);
            check($sformatf("%s_kind", tag), o.kind, x.kind);
            check($sformatf("%s_data", tag), {24'd0, o.data}, {24'd0, x.data});
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int         t0;
        logic [7:0] d;
        logic       stop, par;
        logic [7:0] hi [3];
        hi[0] = 8'h48; hi[1] = 8'h69; hi[2] = 8'h0A;

        q = 1'b1; wb_rst = 1'b1; last_data = 8'h00;
        tick(3);
        check("rst_data", {24'd0, rx_data}, 32'h00);
        check("rst_vld",  {31'd0, rx_vld},  32'd0);
        check("rst_ferr", {31'd0, rx_ferr}, 32'd0);
        check("rst_brk",  {31'd0, rx_brk},  32'd0);
        check("rst_busy", {31'd0, rx_busy}, 32'd0);
        wb_rst = 1'b0;
        tick(5);

        // single clean frame
        send(8'h55, 1'b1, even_par(8'h55));
        tick(20);
        compare("frame55");
        check("frame55_rx_data", {24'd0, rx_data}, 32'h55);

        // short glitch: busy briefly, no strobe
        t0 = cyc;
        q = 1'b0; tick(4); q = 1'b1;
        tick(1);
        check("glitch_busy_high", {31'd0, rx_busy}, 32'd1);
        tick(t0 + 11 - cyc);
        check("glitch_busy_low", {31'd0, rx_busy}, 32'd0);
        tick(20);
        compare("glitch");

        // framing error, then line held low long enough to flag a break
        t0 = cyc;
        send(8'hA3, 1'b0, even_par(8'hA3));
        tick(t0 + LAT + 30 - cyc);
        check("brk_early", {31'd0, rx_brk}, 32'd0);
        tick(20);
        check("brk_set", {31'd0, rx_brk}, 32'd1);
        tick(t0 + FL + 100 - cyc);
        q = 1'b1;
        tick(1);
        check("brk_hold", {31'd0, rx_brk}, 32'd1);
        tick(4);
        check("brk_clear", {31'd0, rx_brk}, 32'd0);
        tick(10);
        compare("ferr");
        check("ferr_rx_data_kept", {24'd0, rx_data}, 32'h55);
        send(8'h0A, 1'b1, even_par(8'h0A));
        tick(20);
        compare("after_ferr");

        // back-to-back frames with no idle: "Hi\n" then random bytes
        for (int i = 0; i < 3; i++) send(hi[i], 1'b1, even_par(hi[i]));
        for (int i = 0; i < 8; i++) begin
            d = 8'($urandom);
            send(d, 1'b1, even_par(d));
        end
        tick(20);
        compare("b2b");

        // random frames with occasional bad stop / parity and random gaps
        for (int i = 0; i < 24; i++) begin
            d    = 8'($urandom);
            stop = ($urandom_range(0, 4) != 0);
            par  = even_par(d) ^ ($urandom_range(0, 3) == 0);
            send(d, stop, par);
            if (!stop) begin
                q = 1'b1;
                tick($urandom_range(4, 12));
            end else begin
                tick($urandom_range(0, 8));
            end
        end
        tick(20);
        compare("random");

`ifdef SERVANT_UART_RX_PARITY_EN
        send(8'h07, 1'b1, 1'b1);
        tick(20);
        compare("par_good");
        check("par_good_data", {24'd0, rx_data}, 32'h07);
        send(8'h07, 1'b1, 1'b0);
        tick(20);
        compare("par_bad");
`endif

        // reset in the middle of a frame aborts it silently
        d = 8'h3C;
        q = 1'b0; tick(C);
        for (int i = 0; i < 3; i++) begin
            q = d[i]; tick(C);
        end
        check("abort_busy", {31'd0, rx_busy}, 32'd1);
        wb_rst = 1'b1;
        #1;
        check("abort_busy_rst", {31'd0, rx_busy}, 32'd0);
        check("abort_data_rst", {24'd0, rx_data}, 32'h00);
        last_data = 8'h00;
        q = 1'b1;
        tick(2);
        wb_rst = 1'b0;
        tick(5);
        send(8'hC3, 1'b1, even_par(8'hC3));
        tick(20);
        compare("abort");
        check("abort_rx_data", {24'd0, rx_data}, 32'hC3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
